// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache between the fetch PC and a slower backing memory.
// A hit returns data in the same cycle. A miss refills the whole line, one word per acknowledged request.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        stallI,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - 2 - WB - IB;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic              r_pend;
  logic [WB-1:0]     r_cnt;
  logic [15:0]       r_miss_count;
  logic [TB-1:0]     r_ltag;
  logic [IB-1:0]     r_lidx;
  logic [TB-1:0]     r_tag  [LINES];
  logic [31:0]       r_data [LINES*WORDS];

  logic [WB-1:0]     w_word;
  logic [IB-1:0]     w_idx;
  logic [TB-1:0]     w_tag;
  logic              w_idle;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill;
  logic              w_last;

  assign w_word = pcF[2 +: WB];
  assign w_idx  = pcF[2+WB +: IB];
  assign w_tag  = pcF[31 -: TB];
  assign w_idle = (r_state == S_IDLE);
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = !reset && w_idle && !w_hit;
  assign w_fill = !reset && (r_state == S_REFILL) && mem_ack;
  assign w_last = w_fill && (r_cnt == '1);

  // Control: state, valid bits, pending invalidate, word counter, miss counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_pend       <= 1'b0;
      r_cnt        <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (invalidate) r_valid <= '0;
          if (!w_hit) begin
            r_cnt   <= '0;
            r_state <= S_REFILL;
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
          end
        end
        S_REFILL: begin
          // The line being filled stays invalid if an invalidate arrived at any point of its refill
          if (invalidate) begin
            r_valid <= '0;
            r_pend  <= 1'b1;
          end
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
              r_valid[r_lidx] <= !(r_pend || invalidate);
              r_pend          <= 1'b0;
              r_state         <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage and latched refill address; not reset
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_ltag <= w_tag;
      r_lidx <= w_idx;
    end
    if (w_fill) r_data[{r_lidx, r_cnt}] <= mem_rdata;
    if (w_last) r_tag[r_lidx] <= r_ltag;
  end

  assign stallI     = !reset && (!w_idle || !w_hit);
  assign instrF     = (!reset && w_idle && w_hit) ? r_data[{w_idx, w_word}] : 32'd0;
  assign mem_req    = !reset && (r_state == S_REFILL);
  assign mem_addr   = mem_req ? {r_ltag, r_lidx, r_cnt, 2'b00} : 32'd0;
  assign miss_count = r_miss_count;

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC register and a slower backing instruction memory.
- Consumes `pcF` and supplies `instrF` to the decode-stage latch.
- On a miss it raises `stallI` and refills one whole line via a req/ack word handshake. The pipeline holds `pcF` while stalled (`stallI` ORed into `stallF`/`stallD` externally).

Parameters:
- `LINES`, 16, number of cache lines; power of 2, ≥2.
- `WORDS`, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `pcF`  in  32  fetch address; bits [1:0] ignored
- `instrF`  out  32  instruction for `pcF`; valid only when `stallI`=0
- `stallI`  out  1  miss/refill in progress; pipeline must hold `pcF`
- `invalidate`  in  1  single-cycle pulse; clear all valid bits
- `mem_req`  out  1  backing-memory read request
- `mem_addr`  out  32  word-aligned refill address
- `mem_ack`  in  1  `mem_rdata` valid this cycle; consumes current request
- `mem_rdata`  in  32  refill data word
- `miss_count`  out  16  saturating count of refills started

Behaviour:
- Address split:
  - offset = `pcF[1:0]`, ignored.
  - word = next log2(`WORDS`) bits.
  - index = next log2(`LINES`) bits.
  - tag = remaining upper bits.
- Storage: per line a valid bit, a tag, and `WORDS` data words. Data and tag arrays are not reset; valid bits are.
- Hit = `valid[index]` & (tag match). Evaluated combinationally in IDLE.
- State machine: IDLE, REFILL.
- IDLE:
  - Hit: `instrF` = data[index][word], `stallI`=0, same cycle (zero-latency hit).
  - Miss: `stallI`=1, `instrF`=0. Latch refill tag/index, word counter := 0, `miss_count` += 1 (saturate at 0xFFFF), go to REFILL.
- REFILL:
  - `mem_req`=1, `stallI`=1, `instrF`=0.
  - `mem_addr` = {latched tag, latched index, counter, 2'b00}; stable until acked.
  - On `mem_ack`: write `mem_rdata` into data[index][counter], counter += 1.
  - On the ack with counter = `WORDS`-1: write tag, set valid (unless an invalidate is pending), clear pending, go to IDLE. `mem_req`=0 in IDLE.
  - Words fill in ascending order, starting at word 0. No critical-word-first.
- Latency:
  - Miss penalty = 1 + Σ(ack wait) cycles.
  - With `mem_ack` asserted every REFILL cycle: 1 + `WORDS` = 5 stall cycles; the hit is delivered on the 6th cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- `invalidate`:
  - In IDLE: clears all valid bits at that edge. A lookup in the same cycle uses the pre-clear valid bits.
  - In REFILL: sets a pending flag. The refill still completes but leaves the line invalid; the refetch then misses again.
- `pcF` changes while `stallI`=1 are a protocol violation; the refill uses the latched index/tag regardless.
- Reset (including mid-refill), at the edge:
  - state := IDLE, all valid := 0, pending := 0, counter := 0, `miss_count` := 0.
  - `mem_req`=0 from the next cycle. Acks of the aborted refill are ignored.
  - While `reset`=1: `stallI`=0, `instrF`=0, `mem_req`=0, `mem_addr`=0.
- Reset values after release: `stallI` follows the first lookup (a miss, since all valid=0), `mem_req`=0, `miss_count`=0.

Test Plan:
- Cold miss:
  - Stimulus: reset, then `pcF`=0x00400000, memory acks every cycle with data 0x1000+i.
  - Required: `stallI`=1 for exactly 5 cycles; `mem_addr` = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
  - Then `stallI`=0 and `instrF`=0x1000; `pcF`=0x0040000C hits with 0x1003; `miss_count`=1.
- Wait states:
  - Stimulus: ack delayed 2 cycles per word.
  - Required: `mem_addr` held stable until each ack; 13 stall cycles; no data written on non-ack cycles.
- Conflict eviction:
  - Stimulus: load 0x00400000, then 0x00400100 (same index, LINES=16), then 0x00400000 again.
  - Required: three refills, `miss_count`=3, correct data each time.
- Invalidate:
  - Stimulus: pulse in IDLE after a fill, then re-fetch.
  - Required: the re-fetch misses.
  - Stimulus: pulse during REFILL.
  - Required: the refill completes, the next lookup misses again, and a second refill follows.
- Reset mid-refill:
  - Stimulus: assert `reset` after 2 acks.
  - Required: `mem_req`=0 after the edge, stray ack ignored, next fetch of the same `pcF` performs a full 4-word refill.
- Counter saturation:
  - Stimulus: force 65536+ misses.
  - Required: `miss_count` holds at 0xFFFF.
